// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: bus widths, response codes and the
// request-arbiter state encoding.
package axi4_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT_B = 3'd2,
    ST_WAIT_R = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_t;

endpackage

// File: rtl/axi4_lite_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from ptr+1 with wrap-around; found is low when no bit is set.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    // i = N wraps back to ptr itself, so the last winner is checked last
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found = 1'b1;
        idx   = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one AXI4-Lite master between NUM_REQ
// requesters; one transaction outstanding, B/R completion monitored, watchdog.
module axi4_lite_req_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ),
  parameter int TIMEOUT = 255,
  parameter int TOW     = 8
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic [NUM_REQ-1:0]         iREQ_VALID,
  input  logic [NUM_REQ-1:0]         iREQ_WRITE,
  input  logic [NUM_REQ*ADDR_W-1:0]  iREQ_ADDR,
  input  logic [NUM_REQ*DATA_W-1:0]  iREQ_WDATA,
  input  logic [NUM_REQ*STRB_W-1:0]  iREQ_WSTRB,
  output logic [NUM_REQ-1:0]         oACK,
  output logic [DATA_W-1:0]          oRDATA,
  output logic [1:0]                 oRESP,
  output logic                       oTIMEOUT,
  output logic                       oBUSY,
  output logic [IDW-1:0]             oGRANT_ID,
  output logic                       oWRITE_START,
  output logic                       oREAD_START,
  output logic [ADDR_W-1:0]          oWRITE_ADDR,
  output logic [DATA_W-1:0]          oWRITE_DATA,
  output logic [ADDR_W-1:0]          oREAD_ADDR,
  output logic [STRB_W-1:0]          oWRITE_STRB,
  input  logic                       iBVALID,
  input  logic                       iBREADY,
  input  logic [1:0]                 iBRESP,
  input  logic                       iRVALID,
  input  logic                       iRREADY,
  input  logic [1:0]                 iRRESP,
  input  logic [DATA_W-1:0]          iRDATA
);

  localparam logic [TOW:0]   TO_LIM  = (TOW+1)'(TIMEOUT);
  localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ-1);

  arb_state_t         state, state_nxt;
  logic [IDW-1:0]     rr_ptr, win_idx;
  logic               win_found, is_wr;
  logic               hs_b, hs_r, wd_exp;
  logic [TOW-1:0]     wd_cnt;
  logic [TOW:0]       wd_inc;
  logic [NUM_REQ-1:0] ack_vec;

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req   (iREQ_VALID),
    .ptr   (rr_ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    hs_b      = iBVALID && iBREADY;
    hs_r      = iRVALID && iRREADY;
    wd_inc    = {1'b0, wd_cnt} + {{TOW{1'b0}}, 1'b1};
    wd_exp    = (TIMEOUT != 0) && (wd_inc == TO_LIM);
    ack_vec   = NUM_REQ'(1) << oGRANT_ID;
    state_nxt = state;
    case (state)
      ST_IDLE:   if (win_found) state_nxt = ST_ISSUE;
      ST_ISSUE:  state_nxt = is_wr ? ST_WAIT_B : ST_WAIT_R;
      ST_WAIT_B: if (hs_b || wd_exp) state_nxt = ST_DONE;
      ST_WAIT_R: if (hs_r || wd_exp) state_nxt = ST_DONE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rr_ptr       <= PTR_RST;
      is_wr        <= 1'b0;
      wd_cnt       <= '0;
      oACK         <= '0;
      oRDATA       <= '0;
      oRESP        <= '0;
      oTIMEOUT     <= 1'b0;
      oBUSY        <= 1'b0;
      oGRANT_ID    <= '0;
      oWRITE_START <= 1'b0;
      oREAD_START  <= 1'b0;
      oWRITE_ADDR  <= '0;
      oWRITE_DATA  <= '0;
      oREAD_ADDR   <= '0;
      oWRITE_STRB  <= '0;
    end else begin
      oWRITE_START <= 1'b0;
      oREAD_START  <= 1'b0;
      oACK         <= '0;
      oBUSY        <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: if (win_found) begin
          rr_ptr       <= win_idx;
          oGRANT_ID    <= win_idx;
          is_wr        <= iREQ_WRITE[win_idx];
          oWRITE_START <= iREQ_WRITE[win_idx];
          oREAD_START  <= !iREQ_WRITE[win_idx];
          if (iREQ_WRITE[win_idx]) begin
            oWRITE_ADDR <= iREQ_ADDR[int'(win_idx)*ADDR_W +: ADDR_W];
            oWRITE_DATA <= iREQ_WDATA[int'(win_idx)*DATA_W +: DATA_W];
            oWRITE_STRB <= iREQ_WSTRB[int'(win_idx)*STRB_W +: STRB_W];
          end else begin
            oREAD_ADDR  <= iREQ_ADDR[int'(win_idx)*ADDR_W +: ADDR_W];
          end
        end
        ST_ISSUE: wd_cnt <= '0;
        // a handshake on the expiry cycle takes precedence over the watchdog
        ST_WAIT_B, ST_WAIT_R: begin
          if (state == ST_WAIT_B && hs_b) begin
            oRESP  <= iBRESP;
            oRDATA <= '0;
            oACK   <= ack_vec;
          end else if (state == ST_WAIT_R && hs_r) begin
            oRESP  <= iRRESP;
            oRDATA <= iRDATA;
            oACK   <= ack_vec;
          end else if (wd_exp) begin
            oRESP    <= RESP_SLVERR;
            oRDATA   <= '0;
            oTIMEOUT <= 1'b1;
            oACK     <= ack_vec;
          end else begin
            wd_cnt <= wd_inc[TOW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Self-checking bench for axi4_lite_req_arbiter: directed scenarios plus a
// randomized run against a rotating-priority reference model.
module tb_axi4_lite_req_arbiter;

  localparam int N   = 3;
  localparam int IDW = 2;
  localparam int TO  = 16;

  logic            iCLK = 1'b0;
  logic            iRST = 1'b0;
  logic [N-1:0]    iREQ_VALID, iREQ_WRITE;
  logic [N*32-1:0] iREQ_ADDR, iREQ_WDATA;
  logic [N*4-1:0]  iREQ_WSTRB;
  logic [N-1:0]    oACK;
  logic [31:0]     oRDATA;
  logic [1:0]      oRESP;
  logic            oTIMEOUT, oBUSY;
  logic [IDW-1:0]  oGRANT_ID;
  logic            oWRITE_START, oREAD_START;
  logic [31:0]     oWRITE_ADDR, oWRITE_DATA, oREAD_ADDR;
  logic [3:0]      oWRITE_STRB;
  logic            iBVALID, iBREADY, iRVALID, iRREADY;
  logic [1:0]      iBRESP, iRRESP;
  logic [31:0]     iRDATA;

  int total = 0;
  int bad   = 0;

  bit          slv_hang  = 1'b0;
  int          slv_delay = 1;
  logic [1:0]  slv_resp  = 2'b00;
  logic [31:0] slv_rdata = 32'h0;

  axi4_lite_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .TOW(8)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iREQ_VALID(iREQ_VALID), .iREQ_WRITE(iREQ_WRITE), .iREQ_ADDR(iREQ_ADDR),
    .iREQ_WDATA(iREQ_WDATA), .iREQ_WSTRB(iREQ_WSTRB),
    .oACK(oACK), .oRDATA(oRDATA), .oRESP(oRESP), .oTIMEOUT(oTIMEOUT),
    .oBUSY(oBUSY), .oGRANT_ID(oGRANT_ID),
    .oWRITE_START(oWRITE_START), .oREAD_START(oREAD_START),
    .oWRITE_ADDR(oWRITE_ADDR), .oWRITE_DATA(oWRITE_DATA),
    .oREAD_ADDR(oREAD_ADDR), .oWRITE_STRB(oWRITE_STRB),
    .iBVALID(iBVALID), .iBREADY(iBREADY), .iBRESP(iBRESP),
    .iRVALID(iRVALID), .iRREADY(iRREADY), .iRRESP(iRRESP), .iRDATA(iRDATA)
  );

  always #5 iCLK = ~iCLK;

  // Slave model: answers a start pulse slv_delay negedges later with a
  // one-cycle B or R valid (handshake lands slv_delay edges after WAIT entry).
  initial begin
    bit sw;
    iBVALID = 1'b0; iRVALID = 1'b0; iBREADY = 1'b1; iRREADY = 1'b1;
    iBRESP = 2'b00; iRRESP = 2'b00; iRDATA = 32'h0;
    forever begin
      @(negedge iCLK);
      if ((oWRITE_START || oREAD_START) && !slv_hang) begin
        sw = oWRITE_START;
        repeat (slv_delay) @(negedge iCLK);
        if (sw) begin
          iBVALID = 1'b1; iBRESP = slv_resp;
        end else begin
          iRVALID = 1'b1; iRRESP = slv_resp; iRDATA = slv_rdata;
        end
        @(negedge iCLK);
        iBVALID = 1'b0; iRVALID = 1'b0; iRDATA = $urandom;
      end
    end
  end

  task automatic set_req(input int k, input bit v, input bit wr,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    iREQ_VALID[k]        = v;
    iREQ_WRITE[k]        = wr;
    iREQ_ADDR[k*32 +: 32]  = a;
    iREQ_WDATA[k*32 +: 32] = d;
    iREQ_WSTRB[k*4 +: 4]   = s;
  endtask

  task automatic wait_start(input int lim, output int n);
    n = 0;
    while (!(oWRITE_START || oREAD_START) && n < lim) begin
      @(negedge iCLK); n++;
    end
  endtask

  task automatic wait_ack(input int lim, output int n);
    n = 0;
    while (oACK == '0 && n < lim) begin
      @(negedge iCLK); n++;
    end
  endtask

  task automatic test_reset;
    iRST = 1'b0;
    iREQ_VALID = '0; iREQ_WRITE = '0; iREQ_ADDR = '0; iREQ_WDATA = '0; iREQ_WSTRB = '0;
    repeat (2) @(negedge iCLK);
    total++;
    if ({oACK, oRDATA, oRESP, oTIMEOUT, oBUSY, oGRANT_ID, oWRITE_START, oREAD_START,
         oWRITE_ADDR, oWRITE_DATA, oREAD_ADDR, oWRITE_STRB} !== '0) begin
      bad++; $display("FAIL reset_outputs: busy=%b ack=%b grant=%0d not all zero", oBUSY, oACK, oGRANT_ID);
    end
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);
    total++;
    if (oBUSY !== 1'b0 || oWRITE_START !== 1'b0 || oREAD_START !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: busy=%b ws=%b rs=%b want 0", oBUSY, oWRITE_START, oREAD_START);
    end
  endtask

  task automatic test_write;
    int n;
    slv_hang = 1'b0; slv_delay = 2; slv_resp = 2'b00;
    set_req(0, 1, 1, 32'h10, 32'hDEADBEEF, 4'hF);
    wait_start(10, n);
    total++;
    if (n >= 10) begin bad++; $display("FAIL wr_start_timeout: waited %0d want <10", n); end
    total++;
    if (oWRITE_START !== 1'b1 || oREAD_START !== 1'b0) begin
      bad++; $display("FAIL wr_start_kind: ws=%b rs=%b want 1 0", oWRITE_START, oREAD_START);
    end
    total++;
    if (oWRITE_ADDR !== 32'h10 || oWRITE_DATA !== 32'hDEADBEEF || oWRITE_STRB !== 4'hF) begin
      bad++; $display("FAIL wr_capture: got %h %h %h want 00000010 deadbeef f", oWRITE_ADDR, oWRITE_DATA, oWRITE_STRB);
    end
    total++;
    if (oGRANT_ID !== 2'd0 || oBUSY !== 1'b1) begin
      bad++; $display("FAIL wr_grant: grant=%0d busy=%b want 0 1", oGRANT_ID, oBUSY);
    end
    @(negedge iCLK);
    total++;
    if (oWRITE_START !== 1'b0) begin bad++; $display("FAIL wr_start_pulse: ws=%b want 0", oWRITE_START); end
    wait_ack(20, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL wr_ack_latency: got %0d want 2", n); end
    total++;
    if (oACK !== 3'b001 || oRESP !== 2'b00 || oRDATA !== 32'h0) begin
      bad++; $display("FAIL wr_ack: ack=%b resp=%b rdata=%h want 001 00 0", oACK, oRESP, oRDATA);
    end
    set_req(0, 0, 0, 0, 0, 0);
    @(negedge iCLK);
    total++;
    if (oBUSY !== 1'b0 || oACK !== 3'b000) begin
      bad++; $display("FAIL wr_after: busy=%b ack=%b want 0 000", oBUSY, oACK);
    end
  endtask

  task automatic test_read;
    int n;
    slv_delay = 1; slv_resp = 2'b00; slv_rdata = 32'h12345678;
    set_req(1, 1, 0, 32'h20, 32'h0, 4'h0);
    wait_start(10, n);
    total++;
    if (oREAD_START !== 1'b1 || oWRITE_START !== 1'b0 || oREAD_ADDR !== 32'h20 || oGRANT_ID !== 2'd1) begin
      bad++; $display("FAIL rd_start: rs=%b ws=%b addr=%h grant=%0d want 1 0 20 1",
                      oREAD_START, oWRITE_START, oREAD_ADDR, oGRANT_ID);
    end
    wait_ack(20, n);
    total++;
    if (n !== 2) begin bad++; $display("FAIL rd_ack_latency: got %0d want 2", n); end
    total++;
    if (oACK !== 3'b010 || oRDATA !== 32'h12345678 || oRESP !== 2'b00) begin
      bad++; $display("FAIL rd_ack: ack=%b rdata=%h resp=%b want 010 12345678 00", oACK, oRDATA, oRESP);
    end
    set_req(1, 0, 0, 0, 0, 0);
    @(negedge iCLK);
  endtask

  task automatic test_back_to_back;
    int n;
    logic [N-1:0] exp_ack;
    slv_delay = 1; slv_resp = 2'b00; slv_rdata = 32'hCAFE0000;
    set_req(0, 1, 1, 32'h100, 32'h0BAD0BAD, 4'h5);
    set_req(1, 1, 0, 32'h200, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      wait_start(10, n);
      total++;
      if (n >= 10 || oGRANT_ID !== 2'(i % 2)) begin
        bad++; $display("FAIL b2b_grant[%0d]: got %0d want %0d", i, oGRANT_ID, i % 2);
      end
      wait_ack(20, n);
      exp_ack = '0; exp_ack[i % 2] = 1'b1;
      total++;
      if (oACK !== exp_ack) begin bad++; $display("FAIL b2b_ack[%0d]: got %b want %b", i, oACK, exp_ack); end
      if (i == 5) begin
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
      end
    end
    @(negedge iCLK);
    total++;
    if (oACK !== 3'b000) begin bad++; $display("FAIL b2b_single_ack: got %b want 000", oACK); end
  endtask

  task automatic test_expiry_edge;
    int n;
    slv_delay = TO; slv_resp = 2'b01; slv_rdata = 32'hA5A50F0F;
    set_req(0, 1, 0, 32'h30, 32'h0, 4'h0);
    wait_start(10, n);
    wait_ack(40, n);
    total++;
    if (n !== TO + 1) begin bad++; $display("FAIL edge_latency: got %0d want %0d", n, TO + 1); end
    total++;
    if (oACK !== 3'b001 || oRESP !== 2'b01 || oRDATA !== 32'hA5A50F0F || oTIMEOUT !== 1'b0) begin
      bad++; $display("FAIL edge_handshake_wins: ack=%b resp=%b rdata=%h to=%b want 001 01 a5a50f0f 0",
                      oACK, oRESP, oRDATA, oTIMEOUT);
    end
    set_req(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge iCLK);
  endtask

  task automatic test_timeout;
    int n;
    slv_hang = 1'b1;
    set_req(0, 1, 0, 32'h40, 32'h0, 4'h0);
    wait_start(10, n);
    wait_ack(40, n);
    total++;
    if (n !== TO + 1) begin bad++; $display("FAIL to_latency: got %0d want %0d", n, TO + 1); end
    total++;
    if (oACK !== 3'b001 || oRESP !== 2'b10 || oRDATA !== 32'h0 || oTIMEOUT !== 1'b1) begin
      bad++; $display("FAIL to_ack: ack=%b resp=%b rdata=%h to=%b want 001 10 0 1", oACK, oRESP, oRDATA, oTIMEOUT);
    end
    set_req(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge iCLK);
    total++;
    if (oTIMEOUT !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", oTIMEOUT); end
  endtask

  task automatic test_reset_mid;
    int n;
    slv_hang = 1'b1;
    set_req(1, 1, 1, 32'h50, 32'h11223344, 4'h3);
    wait_start(10, n);
    total++;
    if (oGRANT_ID !== 2'd1) begin bad++; $display("FAIL rm_grant: got %0d want 1", oGRANT_ID); end
    repeat (3) @(negedge iCLK);
    total++;
    if (oBUSY !== 1'b1) begin bad++; $display("FAIL rm_busy: got %b want 1", oBUSY); end
    iRST = 1'b0;
    #1;
    total++;
    if ({oACK, oRDATA, oRESP, oTIMEOUT, oBUSY, oGRANT_ID, oWRITE_START, oREAD_START,
         oWRITE_ADDR, oWRITE_DATA, oREAD_ADDR, oWRITE_STRB} !== '0) begin
      bad++; $display("FAIL rm_async_clear: busy=%b to=%b grant=%0d waddr=%h not all zero",
                      oBUSY, oTIMEOUT, oGRANT_ID, oWRITE_ADDR);
    end
    set_req(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge iCLK);
    total++;
    if (oACK !== 3'b000) begin bad++; $display("FAIL rm_no_ack: got %b want 000", oACK); end
    iRST = 1'b1;
    slv_hang = 1'b0; slv_delay = 1; slv_resp = 2'b00; slv_rdata = 32'h77;
    set_req(0, 1, 0, 32'h60, 32'h0, 4'h0);
    set_req(1, 1, 0, 32'h70, 32'h0, 4'h0);
    wait_start(10, n);
    total++;
    if (oGRANT_ID !== 2'd0 || oREAD_ADDR !== 32'h60) begin
      bad++; $display("FAIL rm_first_grant: grant=%0d addr=%h want 0 60", oGRANT_ID, oREAD_ADDR);
    end
    wait_ack(20, n);
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    repeat (2) @(negedge iCLK);
  endtask

  task automatic test_random;
    int order[$];
    int n, w;
    bit exp_wr;
    logic [31:0] exp_addr, exp_data, exp_rdata;
    logic [3:0] exp_strb;
    logic [1:0] exp_resp;
    logic [N-1:0] exp_ack;
    iRST = 1'b0;
    @(negedge iCLK);
    iRST = 1'b1;
    order = '{0, 1, 2};
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++)
        if (!iREQ_VALID[k] && $urandom_range(0, 2) == 0)
          set_req(k, 1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      if (iREQ_VALID == '0)
        set_req(int'($urandom_range(0, N - 1)), 1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      slv_delay = int'($urandom_range(1, 5));
      slv_resp  = 2'($urandom_range(0, 3));
      slv_rdata = $urandom;
      // reference: highest-priority requesting id in the rotating order
      w = -1;
      foreach (order[j]) if (w < 0 && iREQ_VALID[order[j]]) w = order[j];
      exp_wr   = iREQ_WRITE[w];
      exp_addr = iREQ_ADDR[w*32 +: 32];
      exp_data = iREQ_WDATA[w*32 +: 32];
      exp_strb = iREQ_WSTRB[w*4 +: 4];
      exp_resp = slv_resp;
      exp_rdata = exp_wr ? 32'h0 : slv_rdata;
      wait_start(10, n);
      total++;
      if (n >= 10 || oGRANT_ID !== 2'(w) || oWRITE_START !== exp_wr || oREAD_START !== !exp_wr) begin
        bad++; $display("FAIL rnd_start[%0d]: grant=%0d ws=%b rs=%b want %0d %b %b",
                        t, oGRANT_ID, oWRITE_START, oREAD_START, w, exp_wr, !exp_wr);
      end
      total++;
      if (exp_wr ? (oWRITE_ADDR !== exp_addr || oWRITE_DATA !== exp_data || oWRITE_STRB !== exp_strb)
                 : (oREAD_ADDR !== exp_addr)) begin
        bad++; $display("FAIL rnd_capture[%0d]: waddr=%h wdata=%h strb=%h raddr=%h want %h %h %h",
                        t, oWRITE_ADDR, oWRITE_DATA, oWRITE_STRB, oREAD_ADDR, exp_addr, exp_data, exp_strb);
      end
      // disturb the in-flight requester's inputs; the captured copy must hold
      iREQ_ADDR[w*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) iREQ_VALID[w] = 1'b0;
      wait_ack(40, n);
      exp_ack = '0; exp_ack[w] = 1'b1;
      total++;
      if (n >= 40 || oACK !== exp_ack || oRESP !== exp_resp || oRDATA !== exp_rdata) begin
        bad++; $display("FAIL rnd_ack[%0d]: ack=%b resp=%b rdata=%h want %b %b %h",
                        t, oACK, oRESP, oRDATA, exp_ack, exp_resp, exp_rdata);
      end
      total++;
      if ((exp_wr ? oWRITE_ADDR : oREAD_ADDR) !== exp_addr) begin
        bad++; $display("FAIL rnd_hold[%0d]: got %h want %h", t, exp_wr ? oWRITE_ADDR : oREAD_ADDR, exp_addr);
      end
      while (order[0] != w) order.push_back(order.pop_front());
      order.push_back(order.pop_front());
      if ($urandom_range(0, 1) == 0)
        set_req(w, 1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      else
        set_req(w, 0, 0, 0, 0, 0);
    end
    iREQ_VALID = '0;
    repeat (2) @(negedge iCLK);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_expiry_edge();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_req_arbiter.md
Name: axi4_lite_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one AXI4-Lite master between NUM_REQ local requesters. It captures one request at a time and drives the master's start/address/data/strobe inputs. It watches the master-side B and R handshakes to detect completion, then returns response and read data to the granted requester. A watchdog ends hung transactions.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
IDW, $clog2(NUM_REQ), grant index width (derived, not overridden)
TIMEOUT, 255, cycles to wait for B/R handshake after start; 0 disables watchdog
TOW, 8, watchdog counter width; TIMEOUT must be < 2**TOW

Ports:
iCLK  in  1  clock
iRST  in  1  asynchronous active-low reset
iREQ_VALID  in  NUM_REQ  per-requester request, held until its oACK bit
iREQ_WRITE  in  NUM_REQ  1=write, 0=read
iREQ_ADDR  in  NUM_REQ*32  packed addresses, requester k at [32k+31:32k]
iREQ_WDATA  in  NUM_REQ*32  packed write data
iREQ_WSTRB  in  NUM_REQ*4  packed write strobes
oACK  out  NUM_REQ  one-cycle completion pulse, one-hot
oRDATA  out  32  read data, valid with oACK
oRESP  out  2  BRESP/RRESP, or 2'b10 on timeout, valid with oACK
oTIMEOUT  out  1  sticky, set on any watchdog expiry, cleared only by reset
oBUSY  out  1  high in any state other than IDLE
oGRANT_ID  out  IDW  index of the current/last granted requester
oWRITE_START  out  1  one-cycle pulse to master
oREAD_START  out  1  one-cycle pulse to master
oWRITE_ADDR, oWRITE_DATA, oREAD_ADDR  out  32 each  registered from the captured request
oWRITE_STRB  out  4  registered captured strobe
iBVALID, iBREADY  in  1 each  master-side write-response handshake (monitored)
iBRESP  in  2  write response
iRVALID, iRREADY  in  1 each  master-side read-data handshake (monitored)
iRRESP  in  2  read response
iRDATA  in  32  read data

Behaviour:
- Reset: all outputs 0. State IDLE. Round-robin pointer = NUM_REQ-1, so requester 0 wins first. Watchdog = 0.
- All outputs are registered. No combinational path from iREQ_* to any output.
- FSM states: IDLE, ISSUE, WAIT_B, WAIT_R, DONE.
- IDLE: if any iREQ_VALID bit is set, pick the first set bit searching from pointer+1 with wrap-around.
  - Capture that requester's write/addr/wdata/wstrb into the o*_ADDR/DATA/STRB registers.
  - Update oGRANT_ID and the pointer to the winner; go to ISSUE.
- ISSUE (exactly 1 cycle): assert oWRITE_START if the request is a write, else oREAD_START. Next state WAIT_B or WAIT_R. Watchdog cleared.
- WAIT_B: on iBVALID&&iBREADY, latch iBRESP and go to DONE.
- WAIT_R: on iRVALID&&iRREADY, latch iRRESP and iRDATA and go to DONE.
- Watchdog in WAIT_*: increments every cycle without a handshake. When it reaches TIMEOUT (nonzero), set oRESP=2'b10, oRDATA=0, set oTIMEOUT, go to DONE.
  - Handshake and expiry in the same cycle: handshake wins and oTIMEOUT is not set.
- DONE (exactly 1 cycle): oACK[oGRANT_ID]=1, with oRESP/oRDATA stable. Next state IDLE.
  - oRDATA for writes = 0.
- Latency: iREQ_VALID seen at edge T gives the start pulse in cycle T+1. A handshake at edge H gives oACK in cycle H+1.
  - Minimum request-to-ack: 4 cycles with a zero-wait slave.
  - Requester must drop or renew iREQ_VALID in the cycle after oACK. A still-high valid is treated as a new request.
- Fairness: a requester that was just served has lowest priority next arbitration. With N requesters all continuously requesting, each is served once per N grants.
- Request dropped before ack (protocol violation): transaction completes with captured values; ack is still pulsed.
- Changes to iREQ_* after capture have no effect on the transaction in flight.
- Reset mid-transaction: immediate return to reset values; no ack is issued.
- Does not issue a new start while the master is busy, because only one transaction is outstanding at a time.

Decomposition:
- Shared package axi4_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - FSM state encodings
  - ADDR_W=32, DATA_W=32, STRB_W=4
- One natural sub-module: rr_pick. It is combinational and takes request vector + pointer, returning winner index and a found flag. It is reusable for a future multi-slave interconnect.

Test Plan:
- Req0 write addr=0x10, data=0xDEADBEEF, strb=0xF; slave BRESP=00 after 2 cycles -> one oWRITE_START pulse, addr/data/strb match, oACK=2'b01 with oRESP=00, oBUSY low afterwards.
- Req1 read addr=0x20; slave returns RDATA=0x12345678, RRESP=00 -> oREAD_START pulse, oACK=2'b10, oRDATA=0x12345678.
- Both requesters held high for 6 transactions -> grant order 0,1,0,1,0,1; never two acks in the same cycle.
- Req0 read with slave never asserting RVALID, TIMEOUT=16 -> oACK[0] exactly 16 cycles after WAIT_R entry, oRESP=10, oRDATA=0, oTIMEOUT stays 1.
- Handshake on the exact expiry cycle -> slave response returned, oTIMEOUT stays 0.
- Reset asserted during WAIT_B -> all outputs 0 immediately, no ack; after release, first arbitration grants requester 0.
